mig_tt_evaluator: RTL
=====================

// Module: mig_tt_evaluator
// PURPOSE
//  Programmable majority-inverter-graph (MIG) evaluator for N_IN-input Boolean functions.
//  Holds a loadable netlist of up to MAX_GATES 3-input majority nodes with complementable fanins.
//  On start it sweeps all 2^N_IN minterms, one per cycle, and assembles the full truth table.
//  It compares that table against a target. Used by the classification flow to check candidate
//  MIG realisations in hardware instead of via fixed per-function netlists.
// PARAMETERS
//  N_IN       7   number of primary inputs; TT_W = 2^N_IN
//  MAX_GATES  8   netlist capacity (majority nodes)
//  SEL_W      $clog2(1+N_IN+MAX_GATES)   fanin select width (derived, localparam)
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          synchronous reset, active-low
//  cfg_valid   in   1          netlist write request
//  cfg_ready   out  1          write accepted when valid&ready
//  cfg_gate    in   $clog2(MAX_GATES)  node index written
//  cfg_fanin   in   3*(SEL_W+1) {inv2,sel2,inv1,sel1,inv0,sel0}
//  cfg_err     out  1          1-cycle pulse: illegal write rejected
//  out_sel     in   SEL_W      signal driving function output (sampled at start)
//  out_inv     in   1          complement function output
//  n_gates     in   $clog2(MAX_GATES+1)  active node count (sampled at start)
//  target_tt   in   TT_W       expected truth table (sampled at start)
//  start       in   1          begin sweep
//  busy        out  1          sweep in progress
//  done        out  1          1-cycle pulse, results valid from this cycle
//  tt_out      out  TT_W       computed truth table
//  match       out  1          tt_out == captured target
//  mis_cnt     out  N_IN+1     popcount(tt_out ^ target)
//  first_mis   out  N_IN       lowest mismatching minterm; 0 when match
// BEHAVIOUR
//  Reset: state IDLE. cfg_ready=1. cfg_err, busy, done, match = 0. tt_out, mis_cnt, first_mis = 0.
//    All node fanins = const0, non-inverted.
//  Signal vector index: 0 = const0; 1..N_IN = x[i-1]; N_IN+1+g = node g output.
//  Node g = MAJ(a^inv0, b^inv1, c^inv2). All fanin sel must be < N_IN+1+g (acyclic).
//    A violating write is dropped and pulses cfg_err.
//  Minterm m drives x[i] = m[i] (x0 = LSB). tt_out[m] = f(m), so tt_out's MSB is minterm TT_W-1.
//  Nodes >= n_gates are ignored. An out_sel referencing an inactive node reads 0.
//  FSM:
//    IDLE/DONE --start--> RUN. On the start edge: clear tt_out, zero the counter, capture
//      target/out_sel/out_inv/n_gates.
//    RUN: each cycle evaluate minterm cnt combinationally and write tt_out[cnt]. cnt++.
//      When cnt == TT_W-1 go to DONE.
//    DONE: results are compared on entry. done=1 for exactly one cycle; the state then reads as IDLE.
//  Latency: start accepted at cycle t. busy=1 for cycles t+1..t+TT_W. done=1 at t+TT_W+1.
//  Comparison pipeline:
//    match, mis_cnt and first_mis update in the done cycle. They hold until the next start.
//  cfg_ready=0 while busy. Writes in RUN are not accepted (no cfg_err).
//    A cfg write and start in the same IDLE cycle: the write lands first, and the sweep uses it.
//  start while busy: ignored. The counter wraps only via DONE and never overruns TT_W.
//  rst_n low mid-sweep: abort next edge to reset values. The netlist is cleared and no done pulse is issued.
// STRUCTURE
//  mig_pkg: fanin_t struct {inv, sel}, state_e {IDLE,RUN,DONE}, CONST0_IDX = 0.
//  Sub-module mig_node: 3 fanin_t + signal vector -> majority output, purely combinational.
//    It is instantiated MAX_GATES times in a generate loop.
//  Top holds the config regfile, FSM, minterm counter, tt shift/insert, and the popcount/priority encoder.
// TESTING
//  1 Node0 = MAJ(x0,x1,x2), n_gates=1, out_sel=N_IN+1, target = {16{8'hE8}} -> match=1, mis_cnt=0.
//  2 Node0 = MAJ(x0,x1,const0) (AND), out_inv=1, target = {16{8'h77}}
//    -> done at start+129, tt_out = {16{8'h77}}, match=1.
//  3 Same as test 1 with target bit 5 flipped -> match=0, mis_cnt=1, first_mis=5.
//  4 Write to node0 with sel = N_IN+2 -> cfg_err pulse, node0 unchanged. Then sweep -> tt_out all 0.
//  5 Three-level chain: node0 = MAJ(x1,x3,x4), node1 = MAJ(x0,x1,x5), node2 = MAJ(x2,n0,n1).
//    Check tt_out against the software model over all 128 minterms.
//  6 Deassert rst_n at minterm 40 -> busy=0 and no done pulse; cfg_ready=1.
//    Restart without reprogramming -> tt_out all 0.

Source files
------------

// File: rtl/mig_pkg.sv
// Shared types and sizing for the MIG truth-table evaluator.
package mig_pkg;

   localparam int unsigned N_IN       = 32'd7;
   localparam int unsigned MAX_GATES  = 32'd8;
   localparam int unsigned TT_W       = 32'd1 << N_IN;
   localparam int unsigned SIG_W      = 32'd1 + N_IN + MAX_GATES;
   localparam int unsigned SEL_W      = $clog2(SIG_W);
   localparam int unsigned GATE_W     = $clog2(MAX_GATES);
   localparam int unsigned NG_W       = $clog2(MAX_GATES + 32'd1);
   localparam int unsigned CNT_W      = N_IN + 32'd1;
   localparam int unsigned FIRST_NODE = N_IN + 32'd1;
   localparam int unsigned FANIN_W    = 32'd3 * (SEL_W + 32'd1);

   localparam logic [SEL_W-1:0] CONST0_IDX = '0;

   typedef struct packed {
      logic             inv;
      logic [SEL_W-1:0] sel;
   } fanin_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam fanin_t FANIN_RST = '{inv: 1'b0, sel: CONST0_IDX};

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/mig_tt_evaluator_if.sv
// Config, sweep-control and result bus of the MIG evaluator.
interface mig_tt_evaluator_if;
   import mig_pkg::*;

   logic               cfg_valid;
   logic               cfg_ready;
   logic [GATE_W-1:0]  cfg_gate;
   logic [FANIN_W-1:0] cfg_fanin;
   logic               cfg_err;
   logic [SEL_W-1:0]   out_sel;
   logic               out_inv;
   logic [NG_W-1:0]    n_gates;
   logic [TT_W-1:0]    target_tt;
   logic               start;
   logic               busy;
   logic               done;
   logic [TT_W-1:0]    tt_out;
   logic               match;
   logic [CNT_W-1:0]   mis_cnt;
   logic [N_IN-1:0]    first_mis;

   modport master (
      output cfg_valid, cfg_gate, cfg_fanin, out_sel, out_inv, n_gates, target_tt, start,
      input  cfg_ready, cfg_err, busy, done, tt_out, match, mis_cnt, first_mis
   );

   modport slave (
      input  cfg_valid, cfg_gate, cfg_fanin, out_sel, out_inv, n_gates, target_tt, start,
      output cfg_ready, cfg_err, busy, done, tt_out, match, mis_cnt, first_mis
   );

endinterface

// File: rtl/mig_node.sv
// One majority node: three complementable fanins picked from the signals below it.
module mig_node
   import mig_pkg::*;
#(
   parameter int unsigned VEC_W = 32'd8
)(
   input  fanin_t [2:0]     fanin_i,
   input  logic [VEC_W-1:0] vec_i,
   output logic             maj_o
);

   localparam logic [VEC_W-1:0] VEC_ONE = {{(VEC_W-1){1'b0}}, 1'b1};

   logic [2:0] pin_s;

   // Out-of-range selects read 0; the config regfile never stores them.
   always_comb begin
      pin_s = 3'b000;
      for (int k = 32'sd0; k < 32'sd3; k++) begin
         pin_s[k] = (|(vec_i & (VEC_ONE << fanin_i[k].sel))) ^ fanin_i[k].inv;
      end
      maj_o = maj3(pin_s);
   end

endmodule

// File: rtl/mig_tt_evaluator.sv
// Programmable MIG evaluator: netlist regfile, minterm sweep FSM and truth-table comparison.
module mig_tt_evaluator
   import mig_pkg::*;
(
   input logic               clk,
   input logic               rst_n,
   mig_tt_evaluator_if.slave bus
);

   localparam logic [N_IN-1:0]  CNT_ONE = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [SIG_W-1:0] SIG_ONE = {{(SIG_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [N_IN-1:0]    cnt_q, cnt_d;
   logic [TT_W-1:0]    tt_q, tt_d;
   logic [TT_W-1:0]    target_q, target_d;
   logic [SEL_W-1:0]   out_sel_q, out_sel_d;
   logic               out_inv_q, out_inv_d;
   logic [NG_W-1:0]    n_gates_q, n_gates_d;
   fanin_t [2:0]       fanin_q [MAX_GATES];
   fanin_t [2:0]       fanin_d [MAX_GATES];
   logic               cfg_err_q, cfg_err_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;
   logic [N_IN-1:0]    first_mis_q, first_mis_d;

   fanin_t [2:0]       fanin_wr_s;
   logic               cfg_ok_s;
   logic               cfg_ready_s;
   logic [SIG_W-1:0]   sig_s;
   logic               f_s;
   logic [TT_W-1:0]    tt_new_s;
   logic [TT_W-1:0]    diff_s;
   logic [CNT_W-1:0]   pop_s;
   logic [N_IN-1:0]    prio_s;

   assign fanin_wr_s  = bus.cfg_fanin;
   assign cfg_ready_s = (state_q != RUN);

   // Each node sees only const0, the inputs and lower nodes, so the chain is acyclic by construction.
   for (genvar g = 0; g < MAX_GATES; g++) begin : gen_node
      logic [N_IN+g:0] vec_s;
      logic            maj_s;
      logic            out_s;
      if (g == 0) begin : gen_base
         assign vec_s = {cnt_q, 1'b0};
      end else begin : gen_link
         assign vec_s = {gen_node[g-1].out_s, gen_node[g-1].vec_s};
      end
      mig_node #(.VEC_W(N_IN + 32'd1 + g)) u_node (
         .fanin_i (fanin_q[g]),
         .vec_i   (vec_s),
         .maj_o   (maj_s)
      );
      assign out_s = maj_s & (n_gates_q > NG_W'(g));
   end

   assign sig_s = {gen_node[MAX_GATES-1].out_s, gen_node[MAX_GATES-1].vec_s};
   assign f_s   = (|(sig_s & (SIG_ONE << out_sel_q))) ^ out_inv_q;

   // A write is legal only if every fanin points strictly below the node being written.
   always_comb begin
      cfg_ok_s = 1'b1;
      for (int k = 32'sd0; k < 32'sd3; k++) begin
         cfg_ok_s = cfg_ok_s & (32'(fanin_wr_s[k].sel) < FIRST_NODE + 32'(bus.cfg_gate));
      end
   end

   // Table including the current minterm, its mismatch count and lowest mismatch.
   always_comb begin
      tt_new_s         = tt_q;
      tt_new_s[cnt_q]  = f_s;
      diff_s           = tt_new_s ^ target_q;
      pop_s            = '0;
      prio_s           = '0;
      for (int i = int'(TT_W) - 32'sd1; i >= 32'sd0; i--) begin
         pop_s = pop_s + CNT_W'(diff_s[i]);
         if (diff_s[i]) begin
            prio_s = N_IN'(i);
         end else begin
            prio_s = prio_s;
         end
      end
   end

   // Next-state, config writes, sweep datapath and result capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tt_d        = tt_q;
      target_d    = target_q;
      out_sel_d   = out_sel_q;
      out_inv_d   = out_inv_q;
      n_gates_d   = n_gates_q;
      fanin_d     = fanin_q;
      cfg_err_d   = 1'b0;
      match_d     = match_q;
      mis_cnt_d   = mis_cnt_q;
      first_mis_d = first_mis_q;
      if (bus.cfg_valid && cfg_ready_s) begin
         if (cfg_ok_s) begin
            fanin_d[bus.cfg_gate] = fanin_wr_s;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else begin
         cfg_err_d = 1'b0;
      end
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d     = RUN;
               cnt_d       = '0;
               tt_d        = '0;
               target_d    = bus.target_tt;
               out_sel_d   = bus.out_sel;
               out_inv_d   = bus.out_inv;
               n_gates_d   = bus.n_gates;
               match_d     = 1'b0;
               mis_cnt_d   = '0;
               first_mis_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            tt_d = tt_new_s;
            if (&cnt_q) begin
               state_d     = DONE;
               cnt_d       = '0;
               match_d     = ~|diff_s;
               mis_cnt_d   = pop_s;
               first_mis_d = prio_s;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tt_q        <= '0;
         target_q    <= '0;
         out_sel_q   <= '0;
         out_inv_q   <= 1'b0;
         n_gates_q   <= '0;
         cfg_err_q   <= 1'b0;
         match_q     <= 1'b0;
         mis_cnt_q   <= '0;
         first_mis_q <= '0;
         for (int g = 32'sd0; g < int'(MAX_GATES); g++) begin
            fanin_q[g] <= {3{FANIN_RST}};
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tt_q        <= tt_d;
         target_q    <= target_d;
         out_sel_q   <= out_sel_d;
         out_inv_q   <= out_inv_d;
         n_gates_q   <= n_gates_d;
         cfg_err_q   <= cfg_err_d;
         match_q     <= match_d;
         mis_cnt_q   <= mis_cnt_d;
         first_mis_q <= first_mis_d;
         fanin_q     <= fanin_d;
      end
   end

   assign bus.cfg_ready = cfg_ready_s;
   assign bus.cfg_err   = cfg_err_q;
   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.tt_out    = tt_q;
   assign bus.match     = match_q;
   assign bus.mis_cnt   = mis_cnt_q;
   assign bus.first_mis = first_mis_q;

endmodule
